// File: rtl/trig_seq_multi.sv
// Multi-channel ultrasonic trigger sequencer: fires one registered, one-hot
// trigger pulse per channel slot, in continuous or single-round mode.
module trig_seq_multi #(
    parameter int CHANNELS  = 4,
    parameter int CH_W      = 2,
    parameter int CNT_W     = 20,
    parameter int PULSE_CYC = 10,
    parameter int SLOT_CYC  = 6000
) (
    input  logic                clk_1m,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic                start,
    output logic [CHANNELS-1:0] trig,
    output logic [CH_W-1:0]     chan_idx,
    output logic                slot_start,
    output logic                round_done,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYC - 1);
    localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(CHANNELS - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [CHANNELS-1:0]   trig_q, trig_d;
    logic                  slot_start_q, slot_start_d;
    logic                  round_done_q, round_done_d;
    logic                  busy_q, busy_d;
    logic                  last_ch_s;
    logic [CH_W-1:0]       ch_next_s;

    // Compare-based decode so non-power-of-two channel counts never alias.
    function automatic logic [CHANNELS-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [CHANNELS-1:0] oh;
        for (int i = 0; i < CHANNELS; i++) begin
            oh[i] = (CH_W'(i) == idx);
        end
        return oh;
    endfunction

    assign last_ch_s = (ch_q == CH_LAST);
    assign ch_next_s = last_ch_s ? {CH_W{1'b0}} : ch_q + CH_W'(1);

    // Next-state logic; registered flags are predicted from the next state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ch_d         = ch_q;
        trig_d       = trig_q;
        slot_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && (!mode || start)) begin
                    state_d      = ST_PULSE;
                    cnt_d        = {CNT_W{1'b0}};
                    ch_d         = {CH_W{1'b0}};
                    trig_d       = onehot({CH_W{1'b0}});
                    slot_start_d = 1'b1;
                end else begin
                    cnt_d  = {CNT_W{1'b0}};
                    trig_d = {CHANNELS{1'b0}};
                end
            end
            ST_PULSE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == PULSE_LAST) begin
                    trig_d  = {CHANNELS{1'b0}};
                    state_d = ST_WAIT;
                end else begin
                    trig_d = trig_q;
                end
            end
            ST_WAIT: begin
                if (cnt_q == SLOT_LAST) begin
                    // en and mode only take effect here, so a slot is never cut short.
                    if (!en || (mode && last_ch_s)) begin
                        state_d = ST_IDLE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d      = ST_PULSE;
                        ch_d         = ch_next_s;
                        cnt_d        = {CNT_W{1'b0}};
                        trig_d       = onehot(ch_next_s);
                        slot_start_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                trig_d  = {CHANNELS{1'b0}};
            end
        endcase
        round_done_d = (state_d == ST_WAIT) && (cnt_d == SLOT_LAST) && (ch_d == CH_LAST);
        busy_d       = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            ch_q         <= {CH_W{1'b0}};
            trig_q       <= {CHANNELS{1'b0}};
            slot_start_q <= 1'b0;
            round_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_q         <= ch_d;
            trig_q       <= trig_d;
            slot_start_q <= slot_start_d;
            round_done_q <= round_done_d;
            busy_q       <= busy_d;
        end
    end

    assign trig       = trig_q;
    assign chan_idx   = ch_q;
    assign slot_start = slot_start_q;
    assign round_done = round_done_q;
    assign busy       = busy_q;

endmodule

// File: doc/trig_seq_multi.md
# trig_seq_multi

Parametrised multi-channel ultrasonic trigger sequencer. It generates a fixed-width trigger pulse on each of CHANNELS ranging sensors in turn, one channel per time slot, so that echoes from different sensors never overlap. It supports continuous and single-round modes and reports the active channel to the downstream echo-capture logic. It runs on the 1 MHz sensor clock and replaces the single-channel free-running trigger generator.

## Interface
- CHANNELS, 4: number of sensors. Must be ≥1.
- CH_W, 2: width of the channel index. Must be ≥ max(1, ceil(log2(CHANNELS))).
- CNT_W, 20: width of the slot counter.
- PULSE_CYC, 10: trigger high time in clk_1m cycles (10 µs at 1 MHz). Must satisfy 1 ≤ PULSE_CYC < SLOT_CYC.
- SLOT_CYC, 6000: length of one channel slot in cycles. Must satisfy SLOT_CYC ≤ 2^CNT_W.
- clk_1m  in  1  sensor clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  sequencer enable.
- mode  in  1  0 = continuous, 1 = single round.
- start  in  1  single-round launch request; sampled only in IDLE with mode=1.
- trig  out  CHANNELS  one-hot trigger outputs, registered.
- chan_idx  out  CH_W  channel owning the current slot.
- slot_start  out  1  one-cycle pulse coincident with the first high cycle of each trigger.
- round_done  out  1  one-cycle pulse in the last cycle of the slot of channel CHANNELS-1.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, PULSE, WAIT. A slot counter cnt counts 0..SLOT_CYC-1 within each slot.
- IDLE → PULSE when en=1 and either mode=0, or mode=1 with start=1.
  - On this transition: ch←0, cnt←0, trig←one-hot(0), slot_start←1.
- PULSE: cnt increments each cycle.
  - At cnt=PULSE_CYC-1: trig←0 and the state moves to WAIT.
- WAIT: cnt increments until cnt=SLOT_CYC-1 (the slot end). At slot end:
  - If ch=CHANNELS-1: round_done=1 for this cycle.
  - If en=0, or (mode=1 and ch=CHANNELS-1): go to IDLE and hold ch.
  - Otherwise: ch←(ch=CHANNELS-1 ? 0 : ch+1), cnt←0, trig←one-hot(next ch), slot_start←1, state←PULSE.
- Channel wrap is explicit. Non-power-of-two CHANNELS never index past CHANNELS-1.
- Deasserting en does not truncate a pulse or a slot. The current slot always completes, then the block goes to IDLE. This guarantees echo listen time for the last fired sensor.
- mode is sampled only at IDLE exit and at slot end. A change of mode mid-slot takes effect at the next slot end.
- start is ignored while busy=1, and ignored when mode=0.
- At most one trig bit is high at any time. trig is glitch-free because it is driven from a register.
- chan_idx = ch at all times, including in IDLE (it holds the last channel used).

## Timing
- Reset (async, rst=0): state=IDLE, cnt=0, ch=0.
  - Outputs at reset: trig=0, chan_idx=0, slot_start=0, round_done=0, busy=0.
- Release of rst is synchronous in effect: the first possible transition happens on the first rising edge with rst=1.
- Launch latency: en/start seen at edge E → trig[0] high from edge E for exactly PULSE_CYC cycles.
- Trigger period per channel is CHANNELS×SLOT_CYC cycles. Rising edges on successive channels are exactly SLOT_CYC cycles apart.
- Continuous mode: round_done pulses every CHANNELS×SLOT_CYC cycles.
- Single-round mode: busy stays high for CHANNELS×SLOT_CYC cycles, then falls on the edge following round_done.
- Back-to-back single rounds:
  - start held high at the IDLE cycle after a round → the new round begins immediately.
  - The minimum gap is 1 IDLE cycle.
- CHANNELS=1: ch stays 0, and round_done coincides with every slot end.
- Reset asserted mid-pulse: trig drops immediately (asynchronously) and all state returns to reset values.

## Test plan
- Reset values: drive rst=0 with en=1 → all outputs 0. Release rst with en=0 → outputs remain 0 for 100 cycles.
- Continuous, CHANNELS=4, PULSE_CYC=10, SLOT_CYC=100, en=1 → trig[0..3] rise at t=0,100,200,300 and then at 400 on trig[0] again.
  - Each pulse lasts exactly 10 cycles. slot_start fires at each rise. round_done fires at t=399 and t=799. The one-hot property is checked every cycle.
- Single round, mode=1, start pulse at t=0 → 4 pulses, round_done at t=399, busy falls at t=400, no further triggers for 1000 cycles.
  - A start pulse at t=50 is ignored.
- en dropped at t=105 (during channel 1's pulse) → the channel 1 pulse completes its full 10 cycles. The block goes to IDLE at t=200, chan_idx=1, and no trig[2] is ever raised.
- rst asserted at t=303 (channel 3 high) → trig=0 immediately. After release with en=1, the sequence restarts at channel 0.
- CHANNELS=3, CH_W=2 → chan_idx cycles 0,1,2,0 and never reaches 3. CHANNELS=1 → trig[0] has period SLOT_CYC and round_done fires every slot.
